// File: rtl/sw_debounce_bit.sv
// Purpose: one switch bit -- 2-flop synchroniser, stability counter, filtered level, rise/fall pulses.
// Latency: a clean level set up before edge k shows on db after edge k+1+STABLE_CYCLES; pulses in the same cycle.
// Backpressure: none; free-running filter, every cycle is consumed.
// Ports: clk/rst (async active-high); raw asynchronous level in; db filtered level;
//        rise/fall one-cycle registered pulses; flip is the combinational "db loads on this edge" strobe.
module sw_debounce_bit #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // db takes the synchronised value once it has disagreed for STABLE_CYCLES edges in a row.
    assign flip = (s2 != db) && (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= flip & s2;
            fall <= flip & ~s2;
            if (s2 == db) begin
                // agreement discards any partial bounce count
                cnt <= '0;
            end else if (flip) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Purpose: debounce a WIDTH-bit slide-switch bus, bits filtered independently, with per-bit edge pulses.
// Latency: 2 sync + STABLE_CYCLES edges from a clean raw change to sw_db; pulses and sw_changed align with new sw_db.
// Backpressure: none; outputs are levels/pulses consumed by downstream logic every cycle.
// Ports: clk/rst (async active-high); sw_raw asynchronous switch bus; sw_db debounced bus;
//        sw_rise/sw_fall per-bit one-cycle pulses; sw_changed OR of all pulses in the same cycle.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] flip;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .raw  (sw_raw[i]),
            .db   (sw_db[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i]),
            .flip (flip[i])
        );
    end

    // Registered from the same strobes that load the pulse registers, so it lines up with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |flip;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

    localparam int S = 4;

    logic       clk;
    logic       rst;
    logic [7:0] sw_raw;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       sw_changed;

    int total;
    int bad;

    // Reference model: raw value present at each edge since reset release, and the
    // edge on which each bit last changed its filtered value.
    logic [7:0] hist [0:1023];
    int         m;
    int         last_load [0:7];
    logic [7:0] mdb;
    logic [7:0] mrise;
    logic [7:0] mfall;
    int         rise_cnt;
    int         fall_cnt;
    int         chg_cnt;

    sw_debounce #(.WIDTH(8), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .sw_db      (sw_db),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .sw_changed (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = 0;
        mdb = 8'h00;
        mrise = 8'h00;
        mfall = 8'h00;
        for (int b = 0; b < 8; b++) last_load[b] = 0;
    endtask

    // A bit flips at edge m when the raw value seen by the filter on each of the
    // last S edges (raw at edge e reaches the filter at edge e+2) disagreed with
    // the filtered value, and none of those edges precede the previous flip.
    task automatic model_edge(input logic [7:0] v);
        m++;
        hist[m] = v;
        mrise = 8'h00;
        mfall = 8'h00;
        for (int b = 0; b < 8; b++) begin
            bit ok;
            ok = (m - S >= last_load[b]);
            for (int j = 0; j < S; j++) begin
                int idx;
                idx = m - 2 - j;
                if (idx < 1) ok = 0;
                else if (hist[idx][b] == mdb[b]) ok = 0;
            end
            if (ok) begin
                mdb[b] = ~mdb[b];
                if (mdb[b]) mrise[b] = 1'b1;
                else        mfall[b] = 1'b1;
                last_load[b] = m;
            end
        end
    endtask

    task automatic step(input logic [7:0] v, input string tag);
        sw_raw = v;
        @(posedge clk);
        model_edge(v);
        #1;
        chk({tag, ".db"},   sw_db,   mdb);
        chk({tag, ".rise"}, sw_rise, mrise);
        chk({tag, ".fall"}, sw_fall, mfall);
        chk({tag, ".chg"},  {7'd0, sw_changed}, {7'd0, |(mrise | mfall)});
        if (sw_rise != 8'h00) rise_cnt++;
        if (sw_fall != 8'h00) fall_cnt++;
        if (sw_changed)       chg_cnt++;
    endtask

    task automatic hold(input logic [7:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) step(v, tag);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        chg_cnt = 0;
        model_reset();

        // Reset held with all switches up: everything stays 0.
        rst = 1'b1;
        sw_raw = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.db",   sw_db,   8'h00);
        chk("rst.rise", sw_rise, 8'h00);
        chk("rst.fall", sw_fall, 8'h00);
        chk("rst.chg",  {7'd0, sw_changed}, 8'h00);
        rst = 1'b0;

        // Release: sw_db goes to FF exactly on the 6th edge, with one rise pulse.
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF, "rel");
            if (i == 5) chk("rel.db5", sw_db, 8'h00);
            if (i == 6) begin
                chk("rel.db6",   sw_db,   8'hFF);
                chk("rel.rise6", sw_rise, 8'hFF);
                chk("rel.chg6",  {7'd0, sw_changed}, 8'h01);
            end
        end
        chk("rel.nrise", 8'(rise_cnt), 8'd1);
        chk("rel.nchg",  8'(chg_cnt),  8'd1);

        hold(8'h00, 8, "clr");

        // Clean single change on bit 0.
        rise_cnt = 0;
        fall_cnt = 0;
        hold(8'h01, 8, "clean");
        chk("clean.db",    sw_db, 8'h01);
        chk("clean.nrise", 8'(rise_cnt), 8'd1);
        chk("clean.nfall", 8'(fall_cnt), 8'd0);

        // Bounce on bit 1, then settle high.
        chg_cnt = 0;
        step(8'h03, "bnc");
        step(8'h01, "bnc");
        step(8'h03, "bnc");
        step(8'h01, "bnc");
        chk("bnc.db",   sw_db, 8'h01);
        for (int i = 1; i <= 8; i++) begin
            step(8'h03, "bnc.hold");
            if (i == 5) chk("bnc.db5", sw_db, 8'h01);
            if (i == 6) chk("bnc.db6", sw_db, 8'h03);
        end
        chk("bnc.nchg", 8'(chg_cnt), 8'd1);

        // Three-cycle glitch on bit 7 is rejected.
        chg_cnt = 0;
        hold(8'h83, 3, "glitch");
        hold(8'h03, 8, "glitch.ret");
        chk("glitch.db",   sw_db, 8'h03);
        chk("glitch.nchg", 8'(chg_cnt), 8'd0);

        // Multi-bit step 0B -> 81: rises and falls land together in one cycle.
        hold(8'h0B, 8, "multi.pre");
        chg_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step(8'h81, "multi");
            if (i == 6) begin
                chk("multi.rise6", sw_rise, 8'h80);
                chk("multi.fall6", sw_fall, 8'h0A);
            end
        end
        chk("multi.db",   sw_db, 8'h81);
        chk("multi.nchg", 8'(chg_cnt), 8'd1);

        // Asynchronous reset pulse in the middle of a count.
        hold(8'h00, 8, "ar.pre");
        hold(8'h03, 4, "ar.cnt");
        #1 rst = 1'b1;
        #1;
        chk("ar.db",   sw_db,   8'h00);
        chk("ar.rise", sw_rise, 8'h00);
        chk("ar.fall", sw_fall, 8'h00);
        chk("ar.chg",  {7'd0, sw_changed}, 8'h00);
        #2 rst = 1'b0;
        model_reset();
        rise_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            step(8'h03, "ar.post");
            if (i == 5) chk("ar.db5", sw_db, 8'h00);
            if (i == 6) chk("ar.db6", sw_db, 8'h03);
        end
        chk("ar.nrise", 8'(rise_cnt), 8'd1);

        // Random bit toggles with random hold times against the model.
        begin
            logic [7:0] cur;
            cur = 8'h03;
            for (int k = 0; k < 60; k++) begin
                cur = cur ^ 8'($urandom & $urandom);
                hold(cur, $urandom_range(1, 7), "rand");
            end
            hold(cur, 8, "rand.settle");
            chk("rand.final", sw_db, cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Input-conditioning stage directly upstream of the lab top-level switch-to-LED logic. It synchronises the raw slide-switch bus, filters contact bounce per bit, and feeds the stable vector to the downstream `sw` input. It also emits one-cycle rise/fall pulses per bit for later counter and FSM labs.

Parameters:
WIDTH, 8, number of switch bits filtered independently
STABLE_CYCLES, 1000000, consecutive cycles a synchronised bit must differ from its filtered value before the filtered value changes (10 ms at 100 MHz); legal range >= 1
CNT_W, $clog2(STABLE_CYCLES+1), per-bit counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
sw_raw  input  WIDTH  raw switch levels, asynchronous to clk
sw_db  output  WIDTH  debounced switch levels, registered; connects to downstream sw
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 0->1
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db bit goes 1->0
sw_changed  output  1  OR-reduction of sw_rise|sw_fall, registered in the same cycle as the pulses

Behaviour:
- Reset, asserted asynchronously: sync stage 1, sync stage 2, all counters, sw_db, sw_rise, sw_fall and sw_changed go to 0 immediately, with no clock required.
- Synchroniser: two flops per bit (s1 <= sw_raw; s2 <= s1). Only s2 is used downstream. There is no combinational path from sw_raw to any output.
- Per bit i, on each rising edge:
  - s2[i] == sw_db[i]: cnt[i] <= 0. Any partial bounce count is discarded.
  - s2[i] != sw_db[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != sw_db[i] and cnt[i] == STABLE_CYCLES-1: sw_db[i] <= s2[i]; cnt[i] <= 0.
- Pulses are registered. sw_rise[i] is 1 exactly in the cycle after the edge where sw_db[i] is loaded 0->1, i.e. it is high in the same cycle as the new sw_db value. sw_fall[i] is the mirror for 1->0. Pulses are 0 in all other cycles.
- Latency: a clean level change on sw_raw[i] that is set up before edge k appears on sw_db[i] after edge k+1+STABLE_CYCLES.
- With STABLE_CYCLES = 1, sw_db tracks s2 with one extra register delay.
- Glitch rejection: a mismatch lasting STABLE_CYCLES-1 or fewer consecutive s2 cycles never changes sw_db and produces no pulse.
- Bits are fully independent. Several bits may change in the same cycle; each raises its own pulse, and sw_changed is 1 once for that cycle.
- A counter never exceeds STABLE_CYCLES-1, so no overflow or wrap is possible.
- Reset mid-count discards the count. After release, a switch still held at 1 needs the full 2+STABLE_CYCLES latency again and then produces a rise pulse.
- Reset release while sw_raw = 0: no pulses are produced.

Decomposition:
- No shared package is needed. CNT_W is a localparam computed in the module.
- Natural sub-module: sw_debounce_bit. It contains one 2-flop synchroniser, one counter, the filtered bit, and the rise/fall registers; parameters are STABLE_CYCLES and CNT_W.
- sw_debounce instantiates sw_debounce_bit WIDTH times in a generate loop and ORs the pulse vectors into the sw_changed register input.

Test Plan:
All scenarios run with STABLE_CYCLES = 4 and a 10 ns clock.
- Reset: hold rst=1 with sw_raw=8'hFF, then release. Require sw_db=8'h00 during reset. sw_db becomes 8'hFF exactly 6 edges after release (2 sync + 4 stable). sw_rise=8'hFF for exactly one cycle, with sw_changed=1 in that cycle.
- Clean single change: sw_raw goes 8'h00 -> 8'h01 and holds. Require sw_db=8'h01 after 6 edges, sw_rise=8'h01 for one cycle, sw_fall=0 throughout.
- Bounce: bit 1 toggles 1,0,1,0 on successive cycles, then holds 1. Require no change on sw_db and no pulse during the toggling. sw_db[1]=1 exactly 6 edges after the final 0->1.
- Glitch: bit 7 goes to 1 for 3 cycles, then returns to 0. Require sw_db[7] to stay 0 and sw_rise, sw_fall and sw_changed to stay 0.
- Multi-bit: sw_raw goes from 8'h0B to 8'h81 in one step. Require sw_rise=8'h80 and sw_fall=8'h0A in the same single cycle, sw_changed=1 once, and final sw_db=8'h81.
- Asynchronous reset mid-count: after sw_raw goes 8'h00 -> 8'h03, pulse rst high for 3 ns between clock edges at count 2. Require all outputs to go 0 before the next edge. After release, sw_db=8'h03 with a full 6-edge latency, plus one rise pulse.
